// File: rtl/div_sched.sv
// div_sched: sequences DIV/DIVU/MTHI/MTLO/MFHI/MFLO against an iterative divider,
// owns the HI/LO registers and stalls the pipeline while a division is in flight.
module div_sched #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic          div_start_q, div_start_d;
  logic          div_signed_q, div_signed_d;
  logic          terr_q, terr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic op_known;
  logic is_idle;
  logic accept;

  // Unknown encodings are invisible: they neither stall nor get accepted.
  assign op_known = (op_code != 3'b000) && (op_code != 3'b111);
  assign is_idle  = (state_q == S_IDLE);
  assign accept   = op_valid && op_known && is_idle;

  assign stall    = op_valid && op_known && !is_idle;
  assign rd_valid = accept && ((op_code == OP_MFHI) || (op_code == OP_MFLO));

  always_comb begin
    rd_data = '0;
    if (accept && (op_code == OP_MFHI)) rd_data = hi_q;
    if (accept && (op_code == OP_MFLO)) rd_data = lo_q;
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_signed_d = div_signed_q;
    div_start_d  = 1'b0;
    terr_d       = terr_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_DIV, OP_DIVU: begin
              // A zero divisor is resolved here without launching the divider.
              if (op_b == '0) begin
                hi_d = op_a;
                lo_d = '1;
              end else begin
                div_a_d      = op_a;
                div_b_d      = op_b;
                div_signed_d = (op_code == OP_DIV);
                div_start_d  = 1'b1;
                state_d      = S_START;
              end
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over an expiring budget.
        if (div_done) begin
          lo_d    = div_q;
          hi_d    = div_r;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      terr_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_start_q  <= div_start_d;
      div_signed_q <= div_signed_d;
      terr_q       <= terr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_start   = div_start_q;
  assign div_signed  = div_signed_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/div_sched.md
# div_sched

Sequencing controller between the CPU decode/execute stage and the iterative divider core. It owns the architectural HI/LO registers and accepts DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It launches the divider with a one-cycle start pulse, writes its quotient and remainder into LO and HI, and stalls the pipeline while a division is in flight. It also handles divide-by-zero without using the divider, and flags a divider that never completes.

## Interface
- TIMEOUT, 64: maximum number of WAIT cycles before the division is abandoned; must be ≥2.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  operation presented this cycle.
- op_code  in  3  operation encoding:
  - 3'b001 DIV, 3'b010 DIVU
  - 3'b011 MTHI, 3'b100 MTLO
  - 3'b101 MFHI, 3'b110 MFLO
  - all other encodings are ignored.
- op_a  in  32  dividend, or MTHI/MTLO data.
- op_b  in  32  divisor.
- stall  out  1  combinational; op not accepted, CPU holds op_valid, op_code, op_a and op_b.
- rd_data  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise.
- rd_valid  out  1  combinational; an MFHI/MFLO is accepted this cycle.
- div_start  out  1  registered one-cycle launch pulse to the divider.
- div_signed  out  1  registered; 1 for DIV, 0 for DIVU.
- div_a, div_b  out  32 each  registered operands; stable from div_start until return to IDLE.
- div_done  in  1  divider completion pulse.
- div_q, div_r  in  32 each  quotient and remainder, valid while div_done=1.
- hi, lo  out  32 each  architectural registers.
- timeout_err  out  1  sticky; cleared only by rst.

## Operation
- FSM states: IDLE, START, WAIT.
- An op is accepted when op_valid=1 and the state is IDLE. stall = op_valid && state≠IDLE.
- IDLE, accepted DIV/DIVU with op_b≠0:
  - latch op_a→div_a, op_b→div_b, signed flag→div_signed;
  - go to START.
- IDLE, accepted DIV/DIVU with op_b=0:
  - no divider launch; state stays IDLE;
  - next edge: hi←op_a, lo←32'hFFFFFFFF.
- IDLE, MTHI: hi←op_a at the next edge. MTLO: lo←op_a at the next edge.
- IDLE, MFHI/MFLO: rd_valid=1 and rd_data=hi or lo in the same cycle, reflecting the current register value.
- Invalid op_code: never stalls, has no effect, rd_valid=0.
- START: div_start=1 for exactly this cycle. div_done is ignored. Go to WAIT; clear the timeout counter.
- WAIT, div_done=1: next edge lo←div_q, hi←div_r; go to IDLE.
- WAIT, div_done=0:
  - counter increments each cycle;
  - if counter=TIMEOUT-1, next edge sets timeout_err=1 and goes to IDLE; hi/lo unchanged.
- Simultaneous div_done and the timeout condition: div_done wins, the result is written, timeout_err is unchanged.
- The controller passes div_q/div_r through unchanged; sign correction belongs to the divider.
- The counter is $clog2(TIMEOUT) bits wide and never wraps; it is cleared on entry to WAIT.

## Timing
- Reset values:
  - state IDLE; hi=lo=0; div_start=0, div_signed=0, div_a=div_b=0; timeout_err=0; counter=0;
  - stall=0 and rd_valid=0 whenever op_valid=0.
- rst mid-operation (START or WAIT): next edge forces all reset values. Any pending result is discarded, even with div_done high that cycle.
- DIV accepted in cycle 0:
  - cycle 1: div_start=1;
  - cycles 2..k: WAIT;
  - div_done at cycle k≥2: hi/lo updated at the end of k, IDLE in cycle k+1.
  - Stall with op_valid=1 covers cycles 1..k.
- An op held under stall is accepted in the first IDLE cycle. An MFHI/MFLO held behind a division therefore returns the new result.
- Minimum DIV latency (accept → hi/lo visible): 3 cycles. Zero-divisor, MTHI and MTLO: 1 cycle.
- Back-to-back DIV in cycle k+1 launches div_start in cycle k+2.
- div_done outside WAIT is ignored.

## Test plan
- Reset, then MTHI 0x12345678 and MTLO 0xCAFEF00D → hi=0x12345678, lo=0xCAFEF00D. Then MFHI → rd_valid=1, rd_data=0x12345678, same cycle.
- DIV a=0xFFFFFFF9, b=2:
  - div_start pulses one cycle with div_signed=1;
  - model returns div_done after 32 cycles with q=0xFFFFFFFD, r=0xFFFFFFFF;
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 with MFLO held on op_valid during the division:
  - stall=1 every busy cycle;
  - MFLO returns 14 in the first IDLE cycle;
  - hi=2.
- DIVU a=0x55, b=0 → no div_start; hi=0x55, lo=0xFFFFFFFF one cycle later; no stall.
- TIMEOUT=8, divider never asserts done:
  - IDLE after 8 WAIT cycles, timeout_err=1, hi/lo unchanged;
  - separately, done coincident with the 8th WAIT cycle → result written, timeout_err=0.
- rst asserted in the same cycle as div_done → hi=lo=0, IDLE, div_start=0, no result written.
